// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the XNOR Fibonacci generator and checker.
// Both sides call lfsr_next, so their polynomials always agree.
package lfsr_pkg;

  localparam int LFSR_MIN_BITS = 3;
  localparam int LFSR_MAX_BITS = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic [LFSR_MAX_BITS-1:0] tap(input int k);
    return LFSR_MAX_BITS'(1) << (k - 1);
  endfunction

  // Maximal-length tap sets; bit k-1 of the mask selects tap k.
  function automatic logic [LFSR_MAX_BITS-1:0] lfsr_taps(input int num_bits);
    logic [LFSR_MAX_BITS-1:0] m;
    m = '0;
    case (num_bits)
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      default: m = tap(LFSR_MIN_BITS) | tap(LFSR_MIN_BITS - 1);
    endcase
    return m;
  endfunction

  // Every tap set has an even number of taps, so the chained XNOR equals an inverted XOR.
  function automatic logic [LFSR_MAX_BITS-1:0] lfsr_next(input logic [LFSR_MAX_BITS-1:0] state,
                                                         input int num_bits);
    logic [LFSR_MAX_BITS-1:0] keep;
    logic                     fb;
    fb   = ~^(state & lfsr_taps(num_bits));
    keep = (num_bits >= LFSR_MAX_BITS) ? '1
                                       : ((LFSR_MAX_BITS'(1) << num_bits) - LFSR_MAX_BITS'(1));
    return {state[LFSR_MAX_BITS-2:0], fb} & keep;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Data and status bundle between a PRBS sink and the LFSR checker.
interface lfsr_checker_if #(
  parameter int NUM_BITS = 8,
  parameter int CNT_W    = 16
);

  logic                i_Data_DV;
  logic [NUM_BITS-1:0] i_Data;
  logic                i_Clear_Count;
  logic                o_Locked;
  logic                o_Error;
  logic                o_Lockup;
  logic [CNT_W-1:0]    o_Err_Count;

  modport master (
    output i_Data_DV, i_Data, i_Clear_Count,
    input  o_Locked, o_Error, o_Lockup, o_Err_Count
  );

  modport slave (
    input  i_Data_DV, i_Data, i_Clear_Count,
    output o_Locked, o_Error, o_Lockup, o_Err_Count
  );

endinterface

// File: rtl/lfsr_err_counter.sv
// Saturating mismatch counter; a clear beats a same-cycle increment.
module lfsr_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Clear,
  input  logic             i_Inc,
  output logic [CNT_W-1:0] o_Count
);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Count <= '0;
    end else if (i_Clear) begin
      o_Count <= '0;
    end else if (i_Inc && (o_Count != {CNT_W{1'b1}})) begin
      o_Count <= o_Count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising XNOR LFSR checker: locks onto the received sequence,
// then flywheels its own prediction and counts mismatches per window.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int LOCK_CNT   = 4,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_ERR = 8,
  parameter int CNT_W      = 16
) (
  input  logic           i_Clk,
  input  logic           i_Rst,
  lfsr_checker_if.slave  bus
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERR + 1);

  function automatic logic [NUM_BITS-1:0] step(input logic [NUM_BITS-1:0] s);
    logic [LFSR_MAX_BITS-1:0] w;
    w               = '0;
    w[NUM_BITS-1:0] = s;
    w               = lfsr_next(w, NUM_BITS);
    return w[NUM_BITS-1:0];
  endfunction

  chk_state_t          r_State;
  logic [NUM_BITS-1:0] r_Prev;
  logic [NUM_BITS-1:0] r_Exp;
  logic                r_Have_Prev;
  logic [MATCH_W-1:0]  r_Match_Cnt;
  logic [WIN_W-1:0]    r_Win_Cnt;
  logic [MISS_W-1:0]   r_Miss_Cnt;
  logic                r_Locked;
  logic                r_Error;
  logic                r_Lockup;

  logic                w_All_Ones;
  logic                w_Pred_Ok;
  logic                w_Mismatch;
  logic                w_Count_Inc;
  logic [NUM_BITS-1:0] w_Data_Next;
  logic [NUM_BITS-1:0] w_Exp_Next;
  logic [MATCH_W-1:0]  w_Match_Next;
  logic [MISS_W-1:0]   w_Miss_Next;
  logic [CNT_W-1:0]    w_Count;

  // The all-ones word is the XNOR lockup state and never counts toward lock.
  always_comb begin
    w_All_Ones   = &bus.i_Data;
    w_Data_Next  = step(bus.i_Data);
    w_Exp_Next   = step(r_Exp);
    w_Pred_Ok    = r_Have_Prev && (bus.i_Data == step(r_Prev)) && !w_All_Ones;
    w_Mismatch   = (bus.i_Data != r_Exp);
    w_Match_Next = r_Match_Cnt + MATCH_W'(1);
    w_Miss_Next  = r_Miss_Cnt + MISS_W'(w_Mismatch);
    w_Count_Inc  = bus.i_Data_DV && (r_State == LOCKED) && w_Mismatch;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State     <= SEARCH;
      r_Prev      <= '0;
      r_Exp       <= '0;
      r_Have_Prev <= 1'b0;
      r_Match_Cnt <= '0;
      r_Win_Cnt   <= '0;
      r_Miss_Cnt  <= '0;
      r_Locked    <= 1'b0;
      r_Error     <= 1'b0;
      r_Lockup    <= 1'b0;
    end else begin
      r_Error  <= 1'b0;
      r_Lockup <= 1'b0;
      if (bus.i_Data_DV) begin
        r_Lockup <= w_All_Ones;
        case (r_State)
          SEARCH: begin
            r_Prev      <= bus.i_Data;
            r_Have_Prev <= 1'b1;
            if (!w_Pred_Ok) begin
              r_Match_Cnt <= '0;
            end else if (w_Match_Next == MATCH_W'(LOCK_CNT)) begin
              r_State     <= LOCKED;
              r_Locked    <= 1'b1;
              r_Match_Cnt <= '0;
              r_Exp       <= w_Data_Next;
              r_Win_Cnt   <= '0;
              r_Miss_Cnt  <= '0;
            end else begin
              r_Match_Cnt <= w_Match_Next;
            end
          end
          LOCKED: begin
            r_Error <= w_Mismatch;
            r_Exp   <= w_Exp_Next;
            // Unlock takes precedence over the window rollover on the same word.
            if (w_Miss_Next == MISS_W'(UNLOCK_ERR)) begin
              r_State     <= SEARCH;
              r_Locked    <= 1'b0;
              r_Match_Cnt <= '0;
              r_Prev      <= bus.i_Data;
              r_Have_Prev <= 1'b1;
              r_Win_Cnt   <= '0;
              r_Miss_Cnt  <= '0;
            end else if (r_Win_Cnt == WIN_W'(WINDOW - 1)) begin
              r_Win_Cnt  <= '0;
              r_Miss_Cnt <= '0;
            end else begin
              r_Win_Cnt  <= r_Win_Cnt + WIN_W'(1);
              r_Miss_Cnt <= w_Miss_Next;
            end
          end
          default: r_State <= SEARCH;
        endcase
      end
    end
  end

  lfsr_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Clear (bus.i_Clear_Count),
    .i_Inc   (w_Count_Inc),
    .o_Count (w_Count)
  );

  assign bus.o_Locked    = r_Locked;
  assign bus.o_Error     = r_Error;
  assign bus.o_Lockup    = r_Lockup;
  assign bus.o_Err_Count = w_Count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker at NUM_BITS=3, LOCK_CNT=4, WINDOW=64, UNLOCK_ERR=8, CNT_W=4.
module tb_lfsr_checker;

  logic i_Clk;
  logic i_Rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   pos          = 0;
  logic [2:0] seq [7];

  lfsr_checker_if #(.NUM_BITS(3), .CNT_W(4)) bus ();

  lfsr_checker #(
    .NUM_BITS   (3),
    .LOCK_CNT   (4),
    .WINDOW     (64),
    .UNLOCK_ERR (8),
    .CNT_W      (4)
  ) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .bus   (bus)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run still active at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send(input logic [2:0] d, input logic clr);
    bus.i_Data_DV     = 1'b1;
    bus.i_Data        = d;
    bus.i_Clear_Count = clr;
    @(posedge i_Clk);
    #1;
    bus.i_Data_DV     = 1'b0;
    bus.i_Clear_Count = 1'b0;
  endtask

  task automatic send_good();
    send(seq[pos], 1'b0);
    pos = (pos + 1) % 7;
  endtask

  // Corrupt word is never all-ones, so only o_Error is exercised.
  task automatic send_bad(input logic clr);
    logic [2:0] e;
    e = seq[pos];
    send((e == 3'b000) ? 3'b001 : 3'b000, clr);
    pos = (pos + 1) % 7;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    bus.i_Data_DV = 1'b0;
    bus.i_Clear_Count = 1'b0;
    idle(2);
    i_Rst = 1'b0;
    pos = 0;
  endtask

  task automatic lock_up();
    repeat (5) send_good();
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.o_Locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_locked: got %b want 0", bus.o_Locked); end
    tests_run++;
    if (bus.o_Error !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_error: got %b want 0", bus.o_Error); end
    tests_run++;
    if (bus.o_Lockup !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_lockup: got %b want 0", bus.o_Lockup); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d want 0", bus.o_Err_Count); end
  endtask

  task automatic test_lock();
    pos = 0;
    repeat (4) send_good();
    tests_run++;
    if (bus.o_Locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_after_4: got %b want 0", bus.o_Locked); end
    send_good();
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL lock_after_5: got %b want 1", bus.o_Locked); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd0) begin tests_failed++; $display("[TB] FAIL lock_count: got %0d want 0", bus.o_Err_Count); end
  endtask

  task automatic test_single_error();
    send(3'b011, 1'b0);
    pos = (pos + 1) % 7;
    tests_run++;
    if (bus.o_Error !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_err_pulse: got %b want 1", bus.o_Error); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd1) begin tests_failed++; $display("[TB] FAIL single_err_count: got %0d want 1", bus.o_Err_Count); end
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_err_locked: got %b want 1", bus.o_Locked); end
    send(3'b100, 1'b0);
    pos = (pos + 1) % 7;
    tests_run++;
    if (bus.o_Error !== 1'b0) begin tests_failed++; $display("[TB] FAIL flywheel_no_err: got %b want 0", bus.o_Error); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd1) begin tests_failed++; $display("[TB] FAIL flywheel_count: got %0d want 1", bus.o_Err_Count); end
  endtask

  task automatic test_lockup_search();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(3'b111, 1'b0);
      tests_run++;
      if (bus.o_Lockup !== 1'b1) begin tests_failed++; $display("[TB] FAIL lockup_pulse[%0d]: got %b want 1", i, bus.o_Lockup); end
      tests_run++;
      if (bus.o_Locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lockup_no_lock[%0d]: got %b want 0", i, bus.o_Locked); end
    end
    idle(1);
    tests_run++;
    if (bus.o_Lockup !== 1'b0) begin tests_failed++; $display("[TB] FAIL lockup_idle: got %b want 0", bus.o_Lockup); end
  endtask

  task automatic test_unlock();
    do_reset();
    lock_up();
    repeat (7) send_bad(1'b0);
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL unlock_7_locked: got %b want 1", bus.o_Locked); end
    send_bad(1'b0);
    tests_run++;
    if (bus.o_Locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL unlock_8_locked: got %b want 0", bus.o_Locked); end
    tests_run++;
    if (bus.o_Error !== 1'b1) begin tests_failed++; $display("[TB] FAIL unlock_8_error: got %b want 1", bus.o_Error); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd8) begin tests_failed++; $display("[TB] FAIL unlock_8_count: got %0d want 8", bus.o_Err_Count); end
  endtask

  task automatic test_window();
    do_reset();
    lock_up();
    repeat (7) send_bad(1'b0);
    repeat (57) send_good();
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL window_roll_locked: got %b want 1", bus.o_Locked); end
    send_bad(1'b0);
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL window_new_miss_locked: got %b want 1", bus.o_Locked); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd8) begin tests_failed++; $display("[TB] FAIL window_count: got %0d want 8", bus.o_Err_Count); end
    do_reset();
    lock_up();
    repeat (56) send_good();
    repeat (7) send_bad(1'b0);
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL window_edge_7: got %b want 1", bus.o_Locked); end
    send_bad(1'b0);
    tests_run++;
    if (bus.o_Locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL window_edge_unlock: got %b want 0", bus.o_Locked); end
  endtask

  task automatic test_saturate();
    do_reset();
    lock_up();
    repeat (8) send_bad(1'b0);
    lock_up();
    repeat (8) send_bad(1'b0);
    tests_run++;
    if (bus.o_Err_Count !== 4'd15) begin tests_failed++; $display("[TB] FAIL sat_16: got %0d want 15", bus.o_Err_Count); end
    lock_up();
    repeat (4) send_bad(1'b0);
    tests_run++;
    if (bus.o_Err_Count !== 4'd15) begin tests_failed++; $display("[TB] FAIL sat_20: got %0d want 15", bus.o_Err_Count); end
    send_bad(1'b1);
    tests_run++;
    if (bus.o_Err_Count !== 4'd0) begin tests_failed++; $display("[TB] FAIL clear_wins: got %0d want 0", bus.o_Err_Count); end
    tests_run++;
    if (bus.o_Error !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear_err_pulse: got %b want 1", bus.o_Error); end
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear_keeps_lock: got %b want 1", bus.o_Locked); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lock_up();
    for (int rep = 0; rep < 2; rep++) begin
      for (int g = 0; g < 4; g++) begin
        send_good();
        tests_run++;
        if (bus.o_Error !== 1'b0) begin tests_failed++; $display("[TB] FAIL gap_err[%0d]: got %b want 0", g, bus.o_Error); end
        idle(g);
      end
    end
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL gap_locked: got %b want 1", bus.o_Locked); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd0) begin tests_failed++; $display("[TB] FAIL gap_count: got %0d want 0", bus.o_Err_Count); end
    send(3'b111, 1'b0);
    pos = (pos + 1) % 7;
    tests_run++;
    if (bus.o_Lockup !== 1'b1) begin tests_failed++; $display("[TB] FAIL locked_lockup: got %b want 1", bus.o_Lockup); end
    tests_run++;
    if (bus.o_Error !== 1'b1) begin tests_failed++; $display("[TB] FAIL locked_lockup_err: got %b want 1", bus.o_Error); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd1) begin tests_failed++; $display("[TB] FAIL locked_lockup_count: got %0d want 1", bus.o_Err_Count); end
  endtask

  task automatic test_reset_mid();
    bus.i_Data_DV = 1'b1;
    bus.i_Data    = seq[pos];
    #3;
    i_Rst = 1'b1;
    #1;
    tests_run++;
    if (bus.o_Locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_locked: got %b want 0", bus.o_Locked); end
    tests_run++;
    if (bus.o_Err_Count !== 4'd0) begin tests_failed++; $display("[TB] FAIL midrst_count: got %0d want 0", bus.o_Err_Count); end
    bus.i_Data_DV = 1'b0;
    idle(1);
    i_Rst = 1'b0;
    pos = 3;
    repeat (4) send_good();
    tests_run++;
    if (bus.o_Locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL relock_4: got %b want 0", bus.o_Locked); end
    send_good();
    tests_run++;
    if (bus.o_Locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL relock_5: got %b want 1", bus.o_Locked); end
  endtask

  initial begin
    seq = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100};
    i_Rst             = 1'b1;
    bus.i_Data_DV     = 1'b0;
    bus.i_Data        = 3'b000;
    bus.i_Clear_Count = 1'b0;
    idle(2);
    i_Rst = 1'b0;
    idle(1);
    test_reset();
    test_lock();
    test_single_error();
    test_lockup_search();
    test_unlock();
    test_window();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
